if_dual_fetch: RTL

- Instruction-fetch requester that drives the dual-read-port synchronous instruction RAM.
- Generates a PC pair {pc, pc+4} each cycle and captures the RAM's 1-cycle-latency read data.
- Presents the instruction pair to decode through a valid/ready handshake, with a skid buffer for backpressure.
- Handles branch redirect: squashes the in-flight read and drives the RAM's branch_flag_i.

---
 rtl/if_dual_fetch_pkg.sv | 32 +++
 rtl/if_skid_buf.sv | 72 +++++++
 rtl/if_dual_fetch.sv | 112 +++++++++++
 3 files changed

// File: rtl/if_dual_fetch_pkg.sv
// ============================================================================
// if_dual_fetch_pkg : shared bus types and constants for the dual fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

package if_dual_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  localparam inst_t      ZERO_WORD        = 32'h0000_0000;
  localparam logic       CHIP_ENABLE      = 1'b1;
  localparam logic       CHIP_DISABLE     = 1'b0;
  localparam inst_addr_t DEFAULT_RESET_PC = 32'h1c00_0000;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst_1;
    inst_t      inst_2;
  } fetch_pair_t;

  function automatic inst_addr_t align_word(input inst_addr_t a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_skid_buf.sv
// ============================================================================
// if_skid_buf : one-entry skid plus output register for {pc, inst_1, inst_2}
// Rev 1.0
// ============================================================================
`default_nettype none

module if_skid_buf
  import if_dual_fetch_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_flush,
  input  logic        i_in_valid,
  input  logic [31:0] i_in_pc,
  input  logic [31:0] i_in_inst_1,
  input  logic [31:0] i_in_inst_2,
  input  logic        i_out_ready,
  output logic        o_out_valid,
  output logic        o_skid_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst_1,
  output logic [31:0] o_inst_2
);

  fetch_pair_t r_out;
  fetch_pair_t r_skid;
  fetch_pair_t w_in;
  logic        r_out_valid;
  logic        r_skid_valid;

  assign w_in = '{pc: i_in_pc, inst_1: i_in_inst_1, inst_2: i_in_inst_2};

  // The producer never delivers while the skid is occupied, so a skid drain
  // and an incoming pair are mutually exclusive.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out        <= '0;
      r_skid       <= '0;
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_out_valid && i_out_ready) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_skid_valid <= 1'b0;
      end else if (i_in_valid) begin
        r_out <= w_in;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (i_in_valid) begin
      if (!r_out_valid) begin
        r_out       <= w_in;
        r_out_valid <= 1'b1;
      end else begin
        r_skid       <= w_in;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_skid_valid = r_skid_valid;
  assign o_pc         = r_out.pc;
  assign o_inst_1     = r_out.inst_1;
  assign o_inst_2     = r_out.inst_2;

endmodule

`default_nettype wire

// File: rtl/if_dual_fetch.sv
// ============================================================================
// if_dual_fetch : dual-slot instruction fetch requester with skid and redirect
// Optional: IF_PERF_CNT_EN adds fetch / flush performance counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module if_dual_fetch
  import if_dual_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] PC_STEP  = 32'd8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ram_ce_o,
  output logic [31:0] ram_raddr_1_o,
  output logic [31:0] ram_raddr_2_o,
  output logic        ram_branch_flag_o,
  input  logic [31:0] ram_rdata_1_i,
  input  logic [31:0] ram_rdata_2_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_1_o,
  output logic [31:0] id_inst_2_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_flush_cnt_o
`endif
);

  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic        r_ce;
  logic        r_inflight;
  logic        w_out_valid;
  logic        w_skid_valid;
  logic        w_skid_fill;
  logic        w_issue;

  // A response parking in the skid this cycle leaves no room for one more.
  assign w_skid_fill = r_inflight & w_out_valid & ~id_ready_i;
  assign w_issue     = r_ce & ~w_skid_valid & ~w_skid_fill & ~branch_flag_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_ce          <= CHIP_DISABLE;
      r_inflight    <= 1'b0;
      r_inflight_pc <= ZERO_WORD;
    end else begin
      r_ce <= CHIP_ENABLE;
      if (branch_flag_i) begin
        r_pc       <= align_word(branch_target_i);
        r_inflight <= 1'b0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_inflight_pc <= r_pc;
          r_pc          <= r_pc + PC_STEP;
        end
      end
    end
  end

  assign ram_ce_o          = r_ce;
  assign ram_raddr_1_o     = r_pc;
  assign ram_raddr_2_o     = r_pc + 32'd4;
  assign ram_branch_flag_o = branch_flag_i;
  assign id_valid_o        = w_out_valid;

  if_skid_buf u_skid (
    .clock        (clock),
    .reset        (reset),
    .i_flush      (branch_flag_i),
    .i_in_valid   (r_inflight),
    .i_in_pc      (r_inflight_pc),
    .i_in_inst_1  (ram_rdata_1_i),
    .i_in_inst_2  (ram_rdata_2_i),
    .i_out_ready  (id_ready_i),
    .o_out_valid  (w_out_valid),
    .o_skid_valid (w_skid_valid),
    .o_pc         (id_pc_o),
    .o_inst_1     (id_inst_1_o),
    .o_inst_2     (id_inst_2_o)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_cnt <= ZERO_WORD;
      r_flush_cnt <= ZERO_WORD;
    end else begin
      if (w_out_valid && id_ready_i) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (branch_flag_i)             r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = r_fetch_cnt;
  assign perf_flush_cnt_o = r_flush_cnt;
`endif

endmodule

`default_nettype wire
